// File: rtl/glyph_cell_scaler.sv
// glyph_cell_scaler
// Turns the raster position stream into glyph-local bit/line counters and
// character-cell column/row indices with per-axis scale factors. The scale
// factors are latched once per frame. All outputs lag the input pixel by
// exactly one clock.
module glyph_cell_scaler #(
    parameter int MAX_SCALE    = 8,
    parameter int CHARA_WIDTH  = 8,
    parameter int CHARA_HEIGHT = 11,
    parameter int COLS         = 80,
    parameter int ROWS         = 40,
    parameter int CORDW        = 16,
    parameter int SW           = $clog2(MAX_SCALE + 1),
    parameter int BW           = $clog2(CHARA_WIDTH),
    parameter int LW           = $clog2(CHARA_HEIGHT),
    parameter int CW           = $clog2(COLS),
    parameter int RW           = $clog2(ROWS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    de,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic [SW-1:0]           scale_x,
    input  logic [SW-1:0]           scale_y,
    output logic                    de_o,
    output logic [BW-1:0]           bit_cnt,
    output logic [LW-1:0]           line_cnt,
    output logic [CW-1:0]           col_idx,
    output logic [RW-1:0]           row_idx,
    output logic                    x_tick,
    output logic                    y_tick,
    output logic                    glyph_valid
);

    // The column/row counters need one extra code for the "beyond grid" value.
    localparam int CIW = $clog2(COLS + 1);
    localparam int RIW = $clog2(ROWS + 1);

    localparam logic [BW-1:0]  BIT_LAST  = BW'(CHARA_WIDTH - 1);
    localparam logic [LW-1:0]  LINE_LAST = LW'(CHARA_HEIGHT - 1);
    localparam logic [CIW-1:0] COL_SAT   = CIW'(COLS);
    localparam logic [RIW-1:0] ROW_SAT   = RIW'(ROWS);
    localparam logic [SW-1:0]  SCALE_MAX = SW'(MAX_SCALE);
    localparam logic [SW-1:0]  SCALE_ONE = SW'(1);

    // Requested scales of 0 behave as 1; anything above the maximum is capped.
    function automatic logic [SW-1:0] clampScale(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        if (s == '0) begin
            r = SCALE_ONE;
        end else if (s > SCALE_MAX) begin
            r = SCALE_MAX;
        end else begin
            r = s;
        end
        return r;
    endfunction

    // Horizontal position is only kept for debug visibility; it plays no part
    // in the counters.
    logic w_unusedSx;
    assign w_unusedSx = ^sx;

    // State registers.
    logic           r_deD;
    logic [SW-1:0]  r_scX;
    logic [SW-1:0]  r_scY;
    logic [SW-1:0]  r_xSub;
    logic [BW-1:0]  r_bit;
    logic [CIW-1:0] r_col;
    logic [SW-1:0]  r_ySub;
    logic [LW-1:0]  r_line;
    logic [RIW-1:0] r_row;

    // Registered single-bit outputs.
    logic r_deO;
    logic r_xTick;
    logic r_yTick;
    logic r_valid;

    // Combinational next-state values.
    logic           w_ls;
    logic           w_fs;
    logic [SW-1:0]  w_scX;
    logic [SW-1:0]  w_scY;
    logic [SW-1:0]  w_scXm1;
    logic [SW-1:0]  w_scYm1;
    logic [SW-1:0]  w_xSubN;
    logic [BW-1:0]  w_bitN;
    logic [CIW-1:0] w_colN;
    logic [SW-1:0]  w_ySubN;
    logic [LW-1:0]  w_lineN;
    logic [RIW-1:0] w_rowN;
    logic           w_xTick;
    logic           w_yTick;
    logic           w_inGrid;

    assign w_ls = de & ~r_deD;
    assign w_fs = w_ls & (sy == '0);

    // The frame-start pixel already runs at the freshly latched scale, so the
    // new value is forwarded straight into this cycle's arithmetic.
    assign w_scX   = w_fs ? clampScale(scale_x) : r_scX;
    assign w_scY   = w_fs ? clampScale(scale_y) : r_scY;
    assign w_scXm1 = w_scX - SCALE_ONE;
    assign w_scYm1 = w_scY - SCALE_ONE;

    // Horizontal sub-pixel, glyph bit and column stepping for active pixels.
    always_comb begin
        w_xSubN = r_xSub;
        w_bitN  = r_bit;
        w_colN  = r_col;
        if (de) begin
            if (w_ls) begin
                w_xSubN = '0;
                w_bitN  = '0;
                w_colN  = '0;
            end else if (r_xSub == w_scXm1) begin
                w_xSubN = '0;
                if (r_bit == BIT_LAST) begin
                    w_bitN = '0;
                    if (r_col != COL_SAT) begin
                        w_colN = r_col + 1'b1;
                    end
                end else begin
                    w_bitN = r_bit + 1'b1;
                end
            end else begin
                w_xSubN = r_xSub + 1'b1;
            end
        end
    end

    // Vertical sub-line, glyph line and row stepping, once per line start.
    always_comb begin
        w_ySubN = r_ySub;
        w_lineN = r_line;
        w_rowN  = r_row;
        if (w_ls) begin
            if (w_fs) begin
                w_ySubN = '0;
                w_lineN = '0;
                w_rowN  = '0;
            end else if (r_ySub == w_scYm1) begin
                w_ySubN = '0;
                if (r_line == LINE_LAST) begin
                    w_lineN = '0;
                    if (r_row != ROW_SAT) begin
                        w_rowN = r_row + 1'b1;
                    end
                end else begin
                    w_lineN = r_line + 1'b1;
                end
            end else begin
                w_ySubN = r_ySub + 1'b1;
            end
        end
    end

    // The sub-line counter is constant across a line, so y_tick derived from
    // it is automatically held for the whole line.
    assign w_xTick  = (w_xSubN == w_scXm1);
    assign w_yTick  = (w_ySubN == w_scYm1);
    assign w_inGrid = (w_colN != COL_SAT) && (w_rowN != ROW_SAT);

    // Counter state, latched scales and line-start detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deD  <= 1'b0;
            r_scX  <= SCALE_ONE;
            r_scY  <= SCALE_ONE;
            r_xSub <= '0;
            r_bit  <= '0;
            r_col  <= '0;
            r_ySub <= '0;
            r_line <= '0;
            r_row  <= '0;
        end else begin
            r_deD  <= de;
            r_scX  <= w_scX;
            r_scY  <= w_scY;
            r_xSub <= w_xSubN;
            r_bit  <= w_bitN;
            r_col  <= w_colN;
            r_ySub <= w_ySubN;
            r_line <= w_lineN;
            r_row  <= w_rowN;
        end
    end

    // Flag outputs: ticks hold through blanking, de_o and glyph_valid drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deO   <= 1'b0;
            r_xTick <= 1'b0;
            r_yTick <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_deO   <= de;
            r_valid <= de & w_inGrid;
            if (de) begin
                r_xTick <= w_xTick;
                r_yTick <= w_yTick;
            end
        end
    end

    // Beyond-grid counter values are presented as the last column/row.
    assign col_idx     = (r_col == COL_SAT) ? CW'(COLS - 1) : r_col[CW-1:0];
    assign row_idx     = (r_row == ROW_SAT) ? RW'(ROWS - 1) : r_row[RW-1:0];
    assign bit_cnt     = r_bit;
    assign line_cnt    = r_line;
    assign de_o        = r_deO;
    assign x_tick      = r_xTick;
    assign y_tick      = r_yTick;
    assign glyph_valid = r_valid;

endmodule
